// File: rtl/ifu_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifu_fetch                                                      |
// | Purpose  : Multi-cycle instruction fetch stage. Owns the architectural    |
// |            PC, issues one read per instruction over a valid/ready AR/R    |
// |            bus, hands the returned word to decode over an                 |
// |            inst_valid/inst_ready handshake and waits for the downstream   |
// |            commit (with next_pc) before fetching again.                   |
// | Ports    : clk, rst                 - clock, synchronous active-high rst  |
// |            araddr/arvalid/arready   - read address channel                |
// |            rdata/rresp/rvalid/rready- read data channel                   |
// |            inst/inst_valid/inst_ready - instruction to decode             |
// |            commit_valid/next_pc     - downstream commit + next PC         |
// |            pc                       - PC of the instruction in flight     |
// |            fetch_err                - sticky fault flag                   |
// |            fetch_count              - instructions delivered to decode    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ifu_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  // read address channel
  output logic [DATA_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  // read data channel
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  // decode interface
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  // commit interface
  input  logic                  commit_valid,
  input  logic [DATA_WIDTH-1:0] next_pc,
  // status
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  fetch_err,
  output logic [31:0]           fetch_count
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_RESP  = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                state_q,  state_d;
  logic [DATA_WIDTH-1:0] pc_q,     pc_d;
  logic [DATA_WIDTH-1:0] inst_q,   inst_d;
  logic                  err_q,    err_d;
  logic [31:0]           count_q,  count_d;

  logic                  w_next_misaligned;

  assign w_next_misaligned = (next_pc[1:0] != 2'b00);

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      err_q   <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    err_d   = err_q;
    count_d = count_q;

    unique case (state_q)
      S_REQ: begin
        // arvalid is high throughout REQ, so arready alone completes it.
        if (arready) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (rvalid) begin
          if (rresp == 2'b00) begin
            inst_d  = rdata;
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end

      S_ISSUE: begin
        if (inst_ready) begin
          count_d = count_q + 32'd1;
          if (commit_valid) begin
            // Single-cycle execute: commit arrives with the issue handshake.
            pc_d = next_pc;
            if (w_next_misaligned) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        if (commit_valid) begin
          // The faulting address is still loaded so pc reports it in ERR.
          pc_d = next_pc;
          if (w_next_misaligned) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // ------------------------------------------------------------------
  assign arvalid     = (state_q == S_REQ);
  assign rready      = (state_q == S_RESP);
  assign inst_valid  = (state_q == S_ISSUE);
  assign araddr      = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign fetch_err   = err_q;
  assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ifu_fetch                                                   |
// | Purpose  : Self-checking bench for ifu_fetch. The bench plays memory and  |
// |            the decode/execute stage, tracking the expected PC, the last   |
// |            delivered instruction and the delivery count at transaction    |
// |            level, and checks every cycle of each fetch against them.      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ifu_fetch;

  localparam logic [31:0] C_RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        commit_valid;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        fetch_err;
  logic [31:0] fetch_count;

  ifu_fetch #(
    .DATA_WIDTH (32),
    .RESET_PC   (C_RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .araddr       (araddr),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rresp        (rresp),
    .rvalid       (rvalid),
    .rready       (rready),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .commit_valid (commit_valid),
    .next_pc      (next_pc),
    .pc           (pc),
    .fetch_err    (fetch_err),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Transaction-level reference state
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic [31:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    arready      = 1'b0;
    rvalid       = 1'b0;
    rdata        = 32'd0;
    rresp        = 2'b00;
    inst_ready   = 1'b0;
    commit_valid = 1'b0;
    next_pc      = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_pc",     pc,                 C_RESET_PC);
    check("rst_inst",   inst,               32'd0);
    check("rst_err",    32'(fetch_err),     32'd0);
    check("rst_count",  fetch_count,        32'd0);
    check("rst_arvld",  32'(arvalid),       32'd1);
    check("rst_araddr", araddr,             C_RESET_PC);
    rst      = 1'b0;
    exp_pc   = C_RESET_PC;
    exp_inst = 32'd0;
    exp_cnt  = 32'd0;
  endtask

  // One complete instruction: address phase (d1 stall cycles), response
  // phase (d2 wait cycles), issue (d3 cycles of inst_ready low), then
  // commit cd cycles after the issue handshake (0 = same cycle).
  task automatic fetch_one(input int d1, input int d2, input int d3, input int cd,
                           input logic [1:0] resp, input logic [31:0] data,
                           input logic [31:0] npc, input bit abort);
    // ---------------- address phase ----------------
    for (int i = 0; i < d1; i++) begin
      check("req_arvalid", 32'(arvalid), 32'd1);
      check("req_araddr",  araddr,       exp_pc);
      check("req_other",   32'({rready, inst_valid}), 32'd0);
      arready      = 1'b0;
      rvalid       = 1'($urandom_range(0, 1));   // ignored while requesting
      rdata        = $urandom;
      rresp        = 2'($urandom_range(0, 3));
      commit_valid = 1'($urandom_range(0, 1));   // ignored while requesting
      next_pc      = $urandom;
      step();
    end
    check("req_arvalid", 32'(arvalid), 32'd1);
    check("req_araddr",  araddr,       exp_pc);
    arready      = 1'b1;
    rvalid       = 1'($urandom_range(0, 1));
    commit_valid = 1'($urandom_range(0, 1));
    next_pc      = $urandom;
    step();
    idle_inputs();
    check("req_pc_hold", pc, exp_pc);

    if (abort) begin
      // Reset mid-response; the stale beat lands in REQ and must be dropped.
      rst = 1'b1;
      step();
      rst    = 1'b0;
      rvalid = 1'b1;
      rdata  = $urandom;
      step();
      idle_inputs();
      check("abort_arvalid", 32'(arvalid),    32'd1);
      check("abort_araddr",  araddr,          C_RESET_PC);
      check("abort_rready",  32'(rready),     32'd0);
      check("abort_ivalid",  32'(inst_valid), 32'd0);
      check("abort_inst",    inst,            32'd0);
      check("abort_count",   fetch_count,     32'd0);
      exp_pc   = C_RESET_PC;
      exp_inst = 32'd0;
      exp_cnt  = 32'd0;
      return;
    end

    // ---------------- response phase ----------------
    for (int i = 0; i < d2; i++) begin
      check("resp_rready", 32'(rready), 32'd1);
      check("resp_other",  32'({arvalid, inst_valid}), 32'd0);
      commit_valid = 1'($urandom_range(0, 1));
      next_pc      = $urandom;
      step();
    end
    idle_inputs();
    check("resp_rready", 32'(rready), 32'd1);
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    step();
    idle_inputs();

    if (resp != 2'b00) begin
      check("rerr_flag", 32'(fetch_err), 32'd1);
      check("rerr_inst", inst,           exp_inst);
      for (int i = 0; i < 20; i++) begin
        check("err_outs", 32'({arvalid, rready, inst_valid}), 32'd0);
        check("err_pc",   pc,                                 exp_pc);
        check("err_flag", 32'(fetch_err),                     32'd1);
        arready      = 1'($urandom_range(0, 1));
        rvalid       = 1'($urandom_range(0, 1));
        inst_ready   = 1'($urandom_range(0, 1));
        commit_valid = 1'($urandom_range(0, 1));
        next_pc      = $urandom;
        step();
      end
      do_reset();
      return;
    end

    // ---------------- issue phase ----------------
    exp_inst = data;
    check("iss_valid", 32'(inst_valid), 32'd1);
    check("iss_inst",  inst,            exp_inst);
    check("iss_pc",    pc,              exp_pc);
    check("iss_arvld", 32'(arvalid),    32'd0);
    for (int i = 0; i < d3; i++) begin
      step();
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_inst",  inst,            exp_inst);
      check("hold_pc",    pc,              exp_pc);
      check("hold_arvld", 32'(arvalid),    32'd0);
      check("hold_count", fetch_count,     exp_cnt);
    end
    inst_ready   = 1'b1;
    commit_valid = (cd == 0);
    next_pc      = (cd == 0) ? npc : $urandom;
    step();
    idle_inputs();
    exp_cnt = exp_cnt + 32'd1;
    check("count", fetch_count, exp_cnt);

    // ---------------- execute wait ----------------
    if (cd > 0) begin
      for (int i = 1; i < cd; i++) begin
        check("exec_outs", 32'({arvalid, rready, inst_valid}), 32'd0);
        check("exec_pc",   pc,                                 exp_pc);
        step();
      end
      check("exec_outs", 32'({arvalid, rready, inst_valid}), 32'd0);
      commit_valid = 1'b1;
      next_pc      = npc;
      step();
      idle_inputs();
    end

    check("commit_pc", pc, npc);
    if (npc[1:0] != 2'b00) begin
      for (int i = 0; i < 5; i++) begin
        check("mis_err",   32'(fetch_err), 32'd1);
        check("mis_pc",    pc,             npc);
        check("mis_arvld", 32'(arvalid),   32'd0);
        commit_valid = 1'($urandom_range(0, 1));
        next_pc      = $urandom;
        step();
      end
      do_reset();
    end else begin
      check("commit_err", 32'(fetch_err), 32'd0);
      exp_pc = npc;
    end
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] npc;
    int          sel;

    idle_inputs();
    rst = 1'b1;
    step();
    do_reset();

    // Zero-wait memory, single-cycle execute: 3 cycles per instruction.
    for (int k = 0; k < 3; k++) begin
      check("zw_araddr", araddr, C_RESET_PC + 32'(4 * k));
      fetch_one(0, 0, 0, 0, 2'b00, 32'h0000_0013, exp_pc + 32'd4, 1'b0);
    end
    check("zw_count", fetch_count, 32'd3);

    // Slow memory, decode backpressure, delayed commit to a jump target.
    fetch_one(5, 4, 3, 2, 2'b00, 32'hDEAD_BEEF, 32'h8000_0100, 1'b0);
    check("jump_araddr", araddr, 32'h8000_0100);

    // Error response, misaligned commit, reset during response.
    fetch_one(1, 2, 0, 0, 2'b10, 32'h1234_5678, 32'd0, 1'b0);
    fetch_one(0, 0, 0, 1, 2'b00, 32'h0000_0013, 32'h8000_0102, 1'b0);
    fetch_one(0, 2, 0, 0, 2'b00, 32'h0000_0013, 32'd0, 1'b1);
    fetch_one(0, 0, 0, 0, 2'b00, 32'h0000_0013, exp_pc + 32'd4, 1'b0);

    // Randomised traffic.
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 19);
      r   = (sel == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (sel == 1)
        npc = {$urandom} | 32'd1;
      else if (sel < 6)
        npc = {$urandom} & ~32'd3;
      else
        npc = exp_pc + 32'd4;
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 3), r, $urandom, npc, (sel == 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
